// File: rtl/vga_pkg.sv
// vga_pkg: shared definitions for the VGA overlay blocks.
//   - keyboard decoder codes (KEY_NONE means no key pressed)
//   - menu_state_t, the screen state shared with the menu text draw stage
//   - select_of(): maps a screen state onto the text ROM selection
package vga_pkg;

  localparam logic [3:0] KEY_NONE  = 4'h0;
  localparam logic [3:0] key_2     = 4'h2;
  localparam logic [3:0] key_3     = 4'h3;
  localparam logic [3:0] key_4     = 4'h4;
  localparam logic [3:0] KEY_UP    = 4'h8;
  localparam logic [3:0] KEY_DOWN  = 4'h9;
  localparam logic [3:0] KEY_ENTER = 4'hA;
  localparam logic [3:0] key_esc   = 4'hF;

  // The state encoding is not the ROM index; TEXT2/TEXT3 are swapped.
  typedef enum logic [1:0] {
    MENU  = 2'b00,
    TEXT1 = 2'b01,
    TEXT2 = 2'b11,
    TEXT3 = 2'b10
  } menu_state_t;

  function automatic logic [1:0] select_of(input menu_state_t s);
    case (s)
      TEXT1:   select_of = 2'b01;
      TEXT2:   select_of = 2'b10;
      TEXT3:   select_of = 2'b11;
      default: select_of = 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/key_event_filter.sv
// key_event_filter: turns a raw keyboard code into single debounced events.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   key[3:0]        raw code from the keyboard decoder
//   key_evt         one-cycle pulse when a new key has been accepted
//   key_code[3:0]   accepted code, valid while key_evt is high
// A code is accepted after DEBOUNCE_CYCLES identical samples. After an event
// the filter disarms and re-arms only once KEY_NONE has been stable for the
// same number of samples, so a held key never repeats and a key held through
// reset must be released before it counts.
module key_event_filter
  import vga_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] key,
  output logic       key_evt,
  output logic [3:0] key_code
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [3:0]    key_q;
  logic [CW-1:0] stable_cnt;
  logic          armed;
  logic          settled;

  assign settled  = (stable_cnt == CNT_MAX);
  assign key_evt  = settled && (key_q != KEY_NONE) && armed;
  assign key_code = key_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q      <= KEY_NONE;
      stable_cnt <= '0;
      armed      <= 1'b0;
    end else begin
      key_q <= key;
      if (key != key_q)
        stable_cnt <= '0;
      else if (!settled)
        stable_cnt <= stable_cnt + CW'(1);

      if (key_evt)
        armed <= 1'b0;
      else if (settled && key_q == KEY_NONE)
        armed <= 1'b1;
    end
  end

endmodule

// File: rtl/menu_ctrl.sv
// menu_ctrl: menu navigation controller for the text overlay renderer.
// Ports:
//   clk, rst_n          pixel clock, asynchronous active-low reset
//   key[3:0]            raw key code from the keyboard decoder
//   vblnk               vertical blank from the timing chain
//   select_text[1:0]    text ROM selection (MENU=0, TEXT1..3=1..3)
//   menu_state[1:0]     menu_state_t for the draw stage
//   cursor[1:0]         highlighted menu entry, 0..2
//   frame_update        one-cycle pulse when menu_state or cursor changed
// Key events are held in a one-entry pending register (latest wins) and are
// applied only at the rising edge of vblnk, so outputs never change mid-frame.
//
// state | meaning
// MENU  | menu screen, cursor navigates entries 0..2
// TEXT1 | text page 1, ESC returns with cursor 0
// TEXT2 | text page 2, ESC returns with cursor 1
// TEXT3 | text page 3, ESC returns with cursor 2
module menu_ctrl
  import vga_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int TIMEOUT_FRAMES  = 600,
  parameter int TO_W            = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] key,
  input  logic       vblnk,
  output logic [1:0] select_text,
  output logic [1:0] menu_state,
  output logic [1:0] cursor,
  output logic       frame_update
);

  localparam int TO_LAST_I = (TIMEOUT_FRAMES > 0) ? TIMEOUT_FRAMES - 1 : 0;
  localparam logic [TO_W-1:0] TO_LAST = TO_LAST_I[TO_W-1:0];

  logic            key_evt;
  logic [3:0]      key_code;
  logic            vblnk_q;
  logic            fe;
  logic            pend_valid;
  logic [3:0]      pend_code;
  menu_state_t     state, nxt_state;
  logic [1:0]      cursor_r, nxt_cursor;
  logic [TO_W-1:0] to_cnt;
  logic            timeout_hit;
  logic            changed;

  key_event_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_filter (
    .clk      (clk),
    .rst_n    (rst_n),
    .key      (key),
    .key_evt  (key_evt),
    .key_code (key_code)
  );

  assign fe          = vblnk & ~vblnk_q;
  assign timeout_hit = (TIMEOUT_FRAMES != 0) && (state != MENU) && (to_cnt == TO_LAST);
  assign changed     = (nxt_state != state) || (nxt_cursor != cursor_r);
  assign menu_state  = state;
  assign cursor      = cursor_r;

  always_comb begin
    nxt_state  = state;
    nxt_cursor = cursor_r;
    if (fe) begin
      if (pend_valid) begin
        if (state == MENU) begin
          case (pend_code)
            key_2:     nxt_state = TEXT1;
            key_3:     nxt_state = TEXT2;
            key_4:     nxt_state = TEXT3;
            KEY_UP:    if (cursor_r != 2'd0) nxt_cursor = cursor_r - 2'd1;
            KEY_DOWN:  if (cursor_r != 2'd2) nxt_cursor = cursor_r + 2'd1;
            KEY_ENTER: begin
              case (cursor_r)
                2'd0:    nxt_state = TEXT1;
                2'd1:    nxt_state = TEXT2;
                default: nxt_state = TEXT3;
              endcase
            end
            default: ;
          endcase
        end else if (pend_code == key_esc) begin
          nxt_state = MENU;
          case (state)
            TEXT1:   nxt_cursor = 2'd0;
            TEXT2:   nxt_cursor = 2'd1;
            default: nxt_cursor = 2'd2;
          endcase
        end
      end else if (timeout_hit) begin
        nxt_state = MENU;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vblnk_q      <= 1'b0;
      pend_valid   <= 1'b0;
      pend_code    <= KEY_NONE;
      state        <= MENU;
      cursor_r     <= 2'd0;
      select_text  <= 2'b00;
      frame_update <= 1'b0;
      to_cnt       <= '0;
    end else begin
      vblnk_q <= vblnk;

      // A new event in the same cycle as fe is kept for the next frame;
      // the command applied at this fe is the one already pending.
      if (key_evt) begin
        pend_valid <= 1'b1;
        pend_code  <= key_code;
      end else if (fe) begin
        pend_valid <= 1'b0;
      end

      state        <= nxt_state;
      cursor_r     <= nxt_cursor;
      select_text  <= select_of(nxt_state);
      frame_update <= changed;

      if (state == MENU || key_evt || changed)
        to_cnt <= '0;
      else if (fe && !pend_valid)
        to_cnt <= to_cnt + TO_W'(1);
    end
  end

endmodule

// File: tb/tb_menu_ctrl.sv
// tb_menu_ctrl: directed bench for menu_ctrl with an abstract screen model
// (page number, cursor, a one-deep command queue, idle-frame count) that is
// compared against the outputs every cycle, plus literal expectations at
// the interesting points of each scenario.
module tb_menu_ctrl;
  import vga_pkg::*;

  localparam int D = 16;
  localparam int T = 3;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] key   = KEY_NONE;
  logic       vblnk = 1'b0;
  logic [1:0] select_text, menu_state, cursor;
  logic       frame_update;

  menu_ctrl #(.DEBOUNCE_CYCLES(D), .TIMEOUT_FRAMES(T), .TO_W(10)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .key          (key),
    .vblnk        (vblnk),
    .select_text  (select_text),
    .menu_state   (menu_state),
    .cursor       (cursor),
    .frame_update (frame_update)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int pulses   = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- abstract model ----------------
  // page: 0 = menu, n = text page n. Encoding of menu_state per page.
  int enc [4] = '{0, 1, 3, 2};
  int m_run_val, m_run_len, m_page, m_cur, m_idle;
  bit m_armed, m_vprev, m_fu;
  int m_q[$];

  always @(posedge clk) begin : model
    bit evt, fe, had, chg;
    int code, p0, c0, cmd;
    if (!rst_n) begin
      m_run_val = 0; m_run_len = 1; m_armed = 0; m_vprev = 0;
      m_page = 0; m_cur = 0; m_idle = 0; m_fu = 0; m_q.delete();
    end else begin
      evt  = (m_run_len >= D) && (m_run_val != 0) && m_armed;
      code = m_run_val;
      if (evt) m_armed = 0;
      else if (m_run_len >= D && m_run_val == 0) m_armed = 1;
      if (int'(key) == m_run_val) m_run_len++;
      else begin m_run_val = int'(key); m_run_len = 1; end

      fe = vblnk && !m_vprev;
      m_vprev = vblnk;
      p0 = m_page; c0 = m_cur; had = (m_q.size() > 0);
      if (fe) begin
        if (had) begin
          cmd = m_q.pop_front();
          if (p0 == 0) begin
            if (cmd == int'(key_2)) m_page = 1;
            else if (cmd == int'(key_3)) m_page = 2;
            else if (cmd == int'(key_4)) m_page = 3;
            else if (cmd == int'(KEY_UP)) m_cur = (m_cur > 0) ? m_cur - 1 : 0;
            else if (cmd == int'(KEY_DOWN)) m_cur = (m_cur < 2) ? m_cur + 1 : 2;
            else if (cmd == int'(KEY_ENTER)) m_page = m_cur + 1;
          end else if (cmd == int'(key_esc)) begin
            m_cur = p0 - 1;
            m_page = 0;
          end
        end else if (p0 != 0 && m_idle == T - 1) begin
          m_page = 0;
        end
      end
      if (evt) begin m_q.delete(); m_q.push_back(code); end
      chg = (m_page != p0) || (m_cur != c0);
      if (p0 == 0 || evt || chg) m_idle = 0;
      else if (fe && !had) m_idle++;
      m_fu = chg;
    end
  end

  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      check("cyc_select_text", select_text, m_page);
      check("cyc_menu_state", menu_state, enc[m_page]);
      check("cyc_cursor", cursor, m_cur);
      check("cyc_frame_update", frame_update, m_fu);
      if (frame_update) pulses++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [3:0] k);
    key = k; cyc(20);
    key = KEY_NONE; cyc(20);
  endtask

  task automatic frame();
    vblnk = 1'b1; cyc(2);
    vblnk = 1'b0; cyc(2);
  endtask

  task automatic check_all(input string name, input int sel, input int ms, input int cur);
    check({name, "_sel"}, select_text, sel);
    check({name, "_ms"}, menu_state, ms);
    check({name, "_cur"}, cursor, cur);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    int exp_c [3] = '{1, 2, 2};

    // Reset held with key_3 down and vblnk toggling.
    rst_n = 1'b0; key = key_3;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); vblnk = 1'($urandom_range(0, 1));
    end
    check_all("in_reset", 0, 0, 0);
    check("in_reset_fu", frame_update, 0);
    @(negedge clk); vblnk = 1'b0; rst_n = 1'b1;
    cyc(30);
    frame();
    check_all("held_thru_reset", 0, 0, 0);
    key = KEY_NONE; cyc(20);

    // Short press: 10 samples are not enough.
    key = key_3; cyc(10); key = KEY_NONE; cyc(20);
    frame();
    check_all("short_press", 0, 0, 0);

    // Full press, fe while still held: TEXT2 exactly 1 clk after fe.
    p0 = pulses;
    key = key_3; cyc(17);
    vblnk = 1'b1;
    check("pre_fe_ms", menu_state, 0);
    @(posedge clk); #1;
    check_all("post_fe", 2, 3, 0);
    check("post_fe_fu", frame_update, 1);
    @(posedge clk); #1;
    check("post_fe_fu_drop", frame_update, 0);
    @(negedge clk); vblnk = 1'b0; cyc(2);
    frame(); frame();
    check("held_one_pulse", pulses - p0, 1);
    check("held_still_text2", menu_state, 3);
    key = KEY_NONE; cyc(20);

    press(key_esc); frame();
    check_all("esc_text2", 0, 0, 1);
    press(KEY_UP); frame();
    check("up_to_0", cursor, 0);

    // Navigation with saturation.
    p0 = pulses;
    for (int i = 0; i < 3; i++) begin
      press(KEY_DOWN); frame();
      check("down_cursor", cursor, exp_c[i]);
    end
    check("down_pulses", pulses - p0, 2);
    press(KEY_ENTER); frame();
    check_all("enter_text3", 3, 2, 2);
    press(key_esc); frame();
    check_all("esc_text3", 0, 0, 2);

    // Latest event wins.
    press(key_2); press(key_4); frame();
    check_all("overwrite", 3, 2, 2);
    press(key_esc); frame();

    // Event in the same cycle as fe with nothing pending.
    key = key_2; cyc(16);
    vblnk = 1'b1; cyc(1);
    check_all("collide_fe", 0, 0, 2);
    vblnk = 1'b0; cyc(3);
    key = KEY_NONE; cyc(20);
    frame();
    check_all("collide_next", 1, 1, 2);

    // Timeout: TEXT1 idle for 3 frames.
    frame(); frame();
    check("idle_f2", menu_state, 1);
    frame();
    check_all("timeout_f3", 0, 0, 2);

    // A non-ESC key restarts the idle count.
    press(key_2); frame();
    frame(); frame();
    press(key_3); frame();
    check("key_restart_f3", menu_state, 1);
    frame(); frame();
    check("key_restart_f5", menu_state, 1);
    frame();
    check_all("key_restart_f6", 0, 0, 2);

    // Asynchronous reset with an ESC pending in TEXT2.
    press(key_3); frame();
    frame(); frame();
    press(key_esc);
    check("pre_rst_ms", menu_state, 3);
    #2 rst_n = 1'b0;
    #1;
    check_all("async_rst", 0, 0, 0);
    cyc(3);
    rst_n = 1'b1;
    cyc(20);
    p0 = pulses;
    frame();
    check_all("after_rst_fe", 0, 0, 0);
    check("after_rst_pulses", pulses - p0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
